vldrdy_rrarb2to1: RTL and testbench

VLDRDY_RRARB2TO1 -- requirements
Module: vldrdy_rrarb2to1

---
 rtl/vldrdy_rrarb2to1_if.sv | 41 ++++
 rtl/vldrdy_rrarb2to1.sv | 117 +++++++++++
 tb/tb_vldrdy_rrarb2to1.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vldrdy_rrarb2to1_if.sv
// Handshake bundle for the two-requester packet arbiter: two valid/ready
// input channels (payload + last flag) and one registered output channel.
interface vldrdy_rrarb2to1_if #(
   parameter int DW = 32
);
   logic          i_valid_1;
   logic          i_ready_1;
   logic [DW-1:0] i_data_1;
   logic          i_last_1;

   logic          i_valid_2;
   logic          i_ready_2;
   logic [DW-1:0] i_data_2;
   logic          i_last_2;

   logic          o_valid;
   logic          o_ready;
   logic [DW-1:0] o_data;
   logic          o_last;
   logic          o_src;

   // Driving side: requesters plus the downstream consumer.
   modport master (
      output i_valid_1, i_data_1, i_last_1,
      input  i_ready_1,
      output i_valid_2, i_data_2, i_last_2,
      input  i_ready_2,
      input  o_valid, o_data, o_last, o_src,
      output o_ready
   );

   // Arbiter side.
   modport slave (
      input  i_valid_1, i_data_1, i_last_1,
      output i_ready_1,
      input  i_valid_2, i_data_2, i_last_2,
      output i_ready_2,
      output o_valid, o_data, o_last, o_src,
      input  o_ready
   );
endinterface

// File: rtl/vldrdy_rrarb2to1.sv
// Two-to-one packet-granular round-robin arbiter with a single registered
// output slot. A packet, once started, locks the grant until its last beat;
// completing a packet hands priority to the other requester.
module vldrdy_rrarb2to1 #(
   parameter int DW = 32
) (
   input logic                 i_clk,
   input logic                 i_rst,
   vldrdy_rrarb2to1_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_1 = 2'd1,
      LOCK_2 = 2'd2
   } state_t;

   state_t        state_reg, state_next;
   logic          prio_reg, prio_next;   // 0 = requester 1 wins a tie
   logic          grant_1, grant_2;
   logic          load;
   logic          acc_1, acc_2;

   logic          o_valid_reg;
   logic [DW-1:0] o_data_reg;
   logic          o_last_reg;
   logic          o_src_reg;

   // The slot can take a new beat when it is empty or being drained.
   assign load = ~o_valid_reg | bus.o_ready;

   // Readies are forced low while reset is held so nothing is accepted.
   assign bus.i_ready_1 = load & grant_1 & ~i_rst;
   assign bus.i_ready_2 = load & grant_2 & ~i_rst;

   assign acc_1 = bus.i_valid_1 & bus.i_ready_1;
   assign acc_2 = bus.i_valid_2 & bus.i_ready_2;

   assign bus.o_valid = o_valid_reg;
   assign bus.o_data  = o_data_reg;
   assign bus.o_last  = o_last_reg;
   assign bus.o_src   = o_src_reg;

   // State and priority pointer registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= IDLE;
         prio_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         prio_reg  <= prio_next;
      end
   end

   // Next state: lock on a non-final beat, release and pass priority on the last.
   always_comb begin
      state_next = state_reg;
      prio_next  = prio_reg;
      if (acc_1) begin
         if (bus.i_last_1) begin
            state_next = IDLE;
            prio_next  = 1'b1;
         end else begin
            state_next = LOCK_1;
         end
      end else if (acc_2) begin
         if (bus.i_last_2) begin
            state_next = IDLE;
            prio_next  = 1'b0;
         end else begin
            state_next = LOCK_2;
         end
      end
   end

   // Grant decode: arbitrate only in IDLE, otherwise hold the locked source.
   always_comb begin
      grant_1 = 1'b0;
      grant_2 = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.i_valid_1 && (!bus.i_valid_2 || !prio_reg))
               grant_1 = 1'b1;
            else if (bus.i_valid_2)
               grant_2 = 1'b1;
         end
         LOCK_1:  grant_1 = 1'b1;
         LOCK_2:  grant_2 = 1'b1;
         default: begin
            grant_1 = 1'b0;
            grant_2 = 1'b0;
         end
      endcase
   end

   // Output slot: capture the accepted beat, empty when nothing arrives, hold when stalled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid_reg <= 1'b0;
         o_data_reg  <= '0;
         o_last_reg  <= 1'b0;
         o_src_reg   <= 1'b0;
      end else if (load) begin
         o_valid_reg <= acc_1 | acc_2;
         if (acc_1) begin
            o_data_reg <= bus.i_data_1;
            o_last_reg <= bus.i_last_1;
            o_src_reg  <= 1'b0;
         end else if (acc_2) begin
            o_data_reg <= bus.i_data_2;
            o_last_reg <= bus.i_last_2;
            o_src_reg  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vldrdy_rrarb2to1.sv
// Bench for the two-to-one round-robin packet arbiter: directed scenarios
// followed by a randomized run against a packet-level reference model.
module tb_vldrdy_rrarb2to1;

   localparam int DW = 32;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 i_clk = ~i_clk;

   vldrdy_rrarb2to1_if #(.DW(DW)) bus();

   vldrdy_rrarb2to1 #(.DW(DW)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_valid_1 = 1'b0;
      bus.i_data_1  = '0;
      bus.i_last_1  = 1'b0;
      bus.i_valid_2 = 1'b0;
      bus.i_data_2  = '0;
      bus.i_last_2  = 1'b0;
      bus.o_ready   = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      i_rst = 1'b1;
      bus.i_valid_1 = 1'b1;
      bus.i_valid_2 = 1'b1;
      bus.o_ready   = 1'b1;
      tick();
      tick();
      checks++;
      if ({bus.o_valid, bus.o_last, bus.o_src} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got v/l/s=%b expected 000", {bus.o_valid, bus.o_last, bus.o_src});
      end
      checks++;
      if (bus.o_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 00000000", bus.o_data);
      end
      checks++;
      if ({bus.i_ready_1, bus.i_ready_2} !== 2'b00) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 00", {bus.i_ready_1, bus.i_ready_2});
      end
      #2;
      i_rst = 1'b0;
      idle_inputs();
      $display("test_reset done");
   endtask

   // Both requesters hold single-beat packets: sources must alternate 1,2,1,2.
   task automatic test_alternate();
      logic [31:0] d1, d2, exp_data;
      logic        exp_src;
      bus.o_ready   = 1'b1;
      bus.i_valid_1 = 1'b1;
      bus.i_valid_2 = 1'b1;
      bus.i_last_1  = 1'b1;
      bus.i_last_2  = 1'b1;
      d1 = 32'h1000_0000;
      d2 = 32'h2000_0000;
      for (int k = 0; k < 4; k++) begin
         bus.i_data_1 = d1;
         bus.i_data_2 = d2;
         exp_src  = (k % 2 == 1);
         exp_data = exp_src ? d2 : d1;
         #1;
         checks++;
         if ({bus.i_ready_1, bus.i_ready_2} !== (exp_src ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL alt_ready[%0d]: got %b expected %b", k, {bus.i_ready_1, bus.i_ready_2}, exp_src ? 2'b01 : 2'b10);
         end
         tick();
         checks++;
         if (bus.o_valid !== 1'b1 || bus.o_src !== exp_src || bus.o_data !== exp_data) begin
            errors++;
            $display("FAIL alt_out[%0d]: got v=%b src=%b data=%h expected v=1 src=%b data=%h",
                     k, bus.o_valid, bus.o_src, bus.o_data, exp_src, exp_data);
         end
         if (exp_src) d2 = d2 + 1; else d1 = d1 + 1;
         $display("alt beat %0d src=%b data=%h", k, bus.o_src, bus.o_data);
      end
   endtask

   // A 3-beat packet from requester 1 locks out requester 2 until its last beat.
   task automatic test_lock();
      bus.o_ready   = 1'b1;
      bus.i_valid_1 = 1'b1;
      bus.i_valid_2 = 1'b1;
      bus.i_last_2  = 1'b1;
      bus.i_data_2  = 32'hBBBB_0000;
      for (int b = 0; b < 3; b++) begin
         bus.i_data_1 = 32'hAAAA_0000 + b;
         bus.i_last_1 = (b == 2);
         #1;
         checks++;
         if ({bus.i_ready_1, bus.i_ready_2} !== 2'b10) begin
            errors++;
            $display("FAIL lock_ready[%0d]: got %b expected 10", b, {bus.i_ready_1, bus.i_ready_2});
         end
         tick();
         checks++;
         if (bus.o_valid !== 1'b1 || bus.o_src !== 1'b0 || bus.o_data !== 32'hAAAA_0000 + b) begin
            errors++;
            $display("FAIL lock_out[%0d]: got v=%b src=%b data=%h expected v=1 src=0 data=%h",
                     b, bus.o_valid, bus.o_src, bus.o_data, 32'hAAAA_0000 + b);
         end
      end
      bus.i_data_1 = 32'hAAAA_0010;
      bus.i_last_1 = 1'b1;
      #1;
      checks++;
      if ({bus.i_ready_1, bus.i_ready_2} !== 2'b01) begin
         errors++;
         $display("FAIL lock_switch_ready: got %b expected 01", {bus.i_ready_1, bus.i_ready_2});
      end
      tick();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_src !== 1'b1 || bus.o_data !== 32'hBBBB_0000) begin
         errors++;
         $display("FAIL lock_switch_out: got v=%b src=%b data=%h expected v=1 src=1 data=bbbb0000",
                  bus.o_valid, bus.o_src, bus.o_data);
      end
      idle_inputs();
      bus.o_ready = 1'b1;
      tick();
      checks++;
      if (bus.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL lock_drain: got o_valid=%b expected 0", bus.o_valid);
      end
      $display("test_lock done");
   endtask

   // Stalled output must hold its beat and block both requesters.
   task automatic test_hold();
      idle_inputs();
      bus.o_ready   = 1'b1;
      bus.i_valid_1 = 1'b1;
      bus.i_data_1  = 32'hA5A5_0001;
      bus.i_last_1  = 1'b1;
      #1;
      checks++;
      if ({bus.i_ready_1, bus.i_ready_2} !== 2'b10) begin
         errors++;
         $display("FAIL hold_load_ready: got %b expected 10", {bus.i_ready_1, bus.i_ready_2});
      end
      tick();
      bus.o_ready   = 1'b0;
      bus.i_data_1  = 32'h1111_2222;
      bus.i_valid_2 = 1'b1;
      bus.i_data_2  = 32'h3333_4444;
      bus.i_last_2  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if ({bus.i_ready_1, bus.i_ready_2} !== 2'b00) begin
            errors++;
            $display("FAIL hold_ready[%0d]: got %b expected 00", k, {bus.i_ready_1, bus.i_ready_2});
         end
         tick();
         checks++;
         if (bus.o_valid !== 1'b1 || bus.o_src !== 1'b0 || bus.o_data !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL hold_out[%0d]: got v=%b src=%b data=%h expected v=1 src=0 data=a5a50001",
                     k, bus.o_valid, bus.o_src, bus.o_data);
         end
      end
      idle_inputs();
      bus.o_ready = 1'b1;
      tick();
      checks++;
      if (bus.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: got o_valid=%b expected 0", bus.o_valid);
      end
      $display("test_hold done");
   endtask

   // Lone requester 2 streams single-beat packets; priority then returns to requester 1.
   task automatic test_lone_req2();
      idle_inputs();
      bus.o_ready   = 1'b1;
      bus.i_valid_2 = 1'b1;
      bus.i_last_2  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.i_data_2 = 32'h2200_0000 + k;
         #1;
         checks++;
         if ({bus.i_ready_1, bus.i_ready_2} !== 2'b01) begin
            errors++;
            $display("FAIL lone_ready[%0d]: got %b expected 01", k, {bus.i_ready_1, bus.i_ready_2});
         end
         tick();
         checks++;
         if (bus.o_valid !== 1'b1 || bus.o_src !== 1'b1 || bus.o_data !== 32'h2200_0000 + k) begin
            errors++;
            $display("FAIL lone_out[%0d]: got v=%b src=%b data=%h expected v=1 src=1 data=%h",
                     k, bus.o_valid, bus.o_src, bus.o_data, 32'h2200_0000 + k);
         end
      end
      bus.i_valid_1 = 1'b1;
      bus.i_data_1  = 32'h1100_0001;
      bus.i_last_1  = 1'b1;
      #1;
      checks++;
      if ({bus.i_ready_1, bus.i_ready_2} !== 2'b10) begin
         errors++;
         $display("FAIL lone_prio: got %b expected 10", {bus.i_ready_1, bus.i_ready_2});
      end
      tick();
      idle_inputs();
      tick();
      $display("test_lone_req2 done");
   endtask

   // Reset during a requester-2 packet drops the lock and restores priority to requester 1.
   task automatic test_reset_mid();
      idle_inputs();
      bus.o_ready   = 1'b1;
      bus.i_valid_2 = 1'b1;
      bus.i_last_2  = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.i_data_2 = 32'h3300_0000 + k;
         #1;
         checks++;
         if (bus.i_ready_2 !== 1'b1) begin
            errors++;
            $display("FAIL rmid_ready[%0d]: got %b expected 1", k, bus.i_ready_2);
         end
         tick();
      end
      bus.i_valid_1 = 1'b1;
      bus.i_data_1  = 32'h1234_5678;
      bus.i_last_1  = 1'b1;
      #1;
      i_rst = 1'b1;
      #1;
      checks++;
      if (bus.o_valid !== 1'b0 || {bus.i_ready_1, bus.i_ready_2} !== 2'b00) begin
         errors++;
         $display("FAIL rmid_async: got v=%b ready=%b expected v=0 ready=00",
                  bus.o_valid, {bus.i_ready_1, bus.i_ready_2});
      end
      tick();
      i_rst = 1'b0;
      #1;
      checks++;
      if ({bus.i_ready_1, bus.i_ready_2} !== 2'b10) begin
         errors++;
         $display("FAIL rmid_grant: got %b expected 10", {bus.i_ready_1, bus.i_ready_2});
      end
      tick();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_src !== 1'b0 || bus.o_data !== 32'h1234_5678) begin
         errors++;
         $display("FAIL rmid_out: got v=%b src=%b data=%h expected v=1 src=0 data=12345678",
                  bus.o_valid, bus.o_src, bus.o_data);
      end
      $display("test_reset_mid done");
   endtask

   // Random traffic against a model of packet ownership and turn-taking.
   task automatic test_random();
      int          owner;     // 0 = no packet open, 1/2 = requester mid-packet
      int          turn;      // requester preferred on the next tie
      bit          m_valid, m_last, m_src;
      logic [31:0] m_data;
      bit          ld, e1, e2, a1, a2;
      int          beats;
      idle_inputs();
      i_rst = 1'b1;
      tick();
      i_rst   = 1'b0;
      owner   = 0;
      turn    = 1;
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_src   = 1'b0;
      m_data  = '0;
      beats   = 0;
      for (int c = 0; c < 10000; c++) begin
         bus.i_valid_1 = ($urandom_range(0, 9) < 7);
         bus.i_data_1  = $urandom;
         bus.i_last_1  = ($urandom_range(0, 2) == 0);
         bus.i_valid_2 = ($urandom_range(0, 9) < 7);
         bus.i_data_2  = $urandom;
         bus.i_last_2  = ($urandom_range(0, 2) == 0);
         bus.o_ready   = ($urandom_range(0, 9) < 7);
         #1;
         ld = !m_valid || bus.o_ready;
         e1 = ld && (owner == 1 || (owner == 0 && bus.i_valid_1 && (!bus.i_valid_2 || turn == 1)));
         e2 = ld && (owner == 2 || (owner == 0 && bus.i_valid_2 && (!bus.i_valid_1 || turn == 2)));
         checks++;
         if (bus.i_ready_1 === 1'b1 && bus.i_ready_2 === 1'b1) begin
            errors++;
            $display("FAIL rand_both_ready[%0d]: got 11 expected at most one high", c);
         end
         checks++;
         if ({bus.i_ready_1, bus.i_ready_2} !== {e1, e2}) begin
            errors++;
            $display("FAIL rand_ready[%0d]: got %b expected %b", c, {bus.i_ready_1, bus.i_ready_2}, {e1, e2});
         end
         a1 = bus.i_valid_1 && e1;
         a2 = bus.i_valid_2 && e2;
         if (ld) begin
            m_valid = a1 || a2;
            if (a1) begin
               m_data = bus.i_data_1; m_last = bus.i_last_1; m_src = 1'b0;
            end else if (a2) begin
               m_data = bus.i_data_2; m_last = bus.i_last_2; m_src = 1'b1;
            end
         end
         if (a1) begin
            owner = bus.i_last_1 ? 0 : 1;
            if (bus.i_last_1) turn = 2;
            beats++;
         end else if (a2) begin
            owner = bus.i_last_2 ? 0 : 2;
            if (bus.i_last_2) turn = 1;
            beats++;
         end
         tick();
         checks++;
         if (bus.o_valid !== m_valid ||
             (m_valid && (bus.o_data !== m_data || bus.o_last !== m_last || bus.o_src !== m_src))) begin
            errors++;
            $display("FAIL rand_out[%0d]: got v=%b d=%h l=%b s=%b expected v=%b d=%h l=%b s=%b",
                     c, bus.o_valid, bus.o_data, bus.o_last, bus.o_src, m_valid, m_data, m_last, m_src);
         end
      end
      $display("test_random done, %0d beats accepted", beats);
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_alternate();
      test_lock();
      test_hold();
      test_lone_req2();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
